// File: rtl/int_controller.sv
// int_controller: prioritised maskable 4-line interrupt controller; edge capture into pending, req/ack handshake to fetch with int_id/int_vector, rti return, cfg register port (GEN/MASK/PENDING/STATUS)
module int_controller #(
  parameter logic [31:0] VEC_BASE   = 32'h0000_0200,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  irq_in,
  input  logic        stall,
  input  logic        int_ack,
  input  logic        rti,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        int_req,
  output logic [1:0]  int_id,
  output logic [31:0] int_vector,
  output logic        in_service
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t      state_q, state_d;
  logic [3:0]  sync1_q, sync2_q, sync2d_q;
  logic [3:0]  pending_q, pending_d, mask_q, mask_d;
  logic        gen_q, gen_d;
  logic        int_req_q, int_req_d, in_service_q, in_service_d;
  logic [1:0]  int_id_q, int_id_d, nxt_id;
  logic [31:0] vec_q, vec_d;
  logic [3:0]  edges, pm, w1c, ack_clr;
  logic        cfg_unused;
  assign cfg_unused = ^cfg_wdata[31:4];
  always_comb begin
    edges   = sync2_q & ~sync2d_q;
    pm      = pending_q & mask_q;
    nxt_id  = pm[0] ? 2'd0 : pm[1] ? 2'd1 : pm[2] ? 2'd2 : 2'd3;
    gen_d   = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata[0] : gen_q;
    mask_d  = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata[3:0] : mask_q;
    w1c     = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[3:0] : 4'b0;
    state_d      = state_q;
    int_req_d    = int_req_q;
    in_service_d = in_service_q;
    int_id_d     = int_id_q;
    vec_d        = vec_q;
    ack_clr      = 4'b0;
    case (state_q)
      IDLE: if (gen_q && |pm && !stall) begin
        state_d   = REQ;
        int_req_d = 1'b1;
        int_id_d  = nxt_id;
        vec_d     = VEC_BASE + VEC_STRIDE * {30'b0, nxt_id};
      end
      REQ: if (int_ack) begin
        state_d      = SERVICE;
        int_req_d    = 1'b0;
        in_service_d = 1'b1;
        ack_clr      = 4'b1 << int_id_q;
      end
      default: if (rti) begin
        state_d      = IDLE;
        in_service_d = 1'b0;
      end
    endcase
    // new edges are ORed in last so they win over both clear sources
    pending_d = (pending_q & ~w1c & ~ack_clr) | edges;
  end
  assign cfg_rdata = cfg_addr == 2'd0 ? {31'b0, gen_q} :
                     cfg_addr == 2'd1 ? {28'b0, mask_q} :
                     cfg_addr == 2'd2 ? {28'b0, pending_q} :
                     {27'b0, in_service_q, int_req_q, 1'b0, int_id_q};
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync2d_q     <= '0;
      pending_q    <= '0;
      mask_q       <= '0;
      gen_q        <= 1'b0;
      int_req_q    <= 1'b0;
      in_service_q <= 1'b0;
      int_id_q     <= '0;
      vec_q        <= VEC_BASE;
    end else begin
      state_q      <= state_d;
      sync1_q      <= irq_in;
      sync2_q      <= sync1_q;
      sync2d_q     <= sync2_q;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      gen_q        <= gen_d;
      int_req_q    <= int_req_d;
      in_service_q <= in_service_d;
      int_id_q     <= int_id_d;
      vec_q        <= vec_d;
    end
  end
  assign int_req    = int_req_q;
  assign int_id     = int_id_q;
  assign int_vector = vec_q;
  assign in_service = in_service_q;
endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller: directed self-checking bench for int_controller
module tb_int_controller;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  irq_in = '0;
  logic        stall = 1'b0, int_ack = 1'b0, rti = 1'b0, cfg_we = 1'b0;
  logic [1:0]  cfg_addr = '0;
  logic [31:0] cfg_wdata = '0;
  logic [31:0] cfg_rdata, int_vector;
  logic        int_req, in_service;
  logic [1:0]  int_id;
  int          n = 0, errs = 0;
  int_controller dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .stall(stall), .int_ack(int_ack),
    .rti(rti), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata), .int_req(int_req), .int_id(int_id),
    .int_vector(int_vector), .in_service(in_service)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, exp);
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = d;
    tick();
    cfg_we = 1'b0;
  endtask
  task automatic ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask
  task automatic ret();
    rti = 1'b1;
    tick();
    rti = 1'b0;
  endtask
  task automatic pulse(input logic [3:0] v);
    irq_in = v;
    tick();
    irq_in = '0;
  endtask
  initial begin
    tick();
    tick();
    reset = 1'b0;
    chk("rst_req", {31'b0, int_req}, 32'h0);
    chk("rst_id", {30'b0, int_id}, 32'h0);
    chk("rst_vec", int_vector, 32'h200);
    chk("rst_insvc", {31'b0, in_service}, 32'h0);
    rd("rst_status", 2'd3, 32'h0);
    rd("rst_pend", 2'd2, 32'h0);
    wr(2'd0, 32'h1);
    wr(2'd1, 32'hF);
    rd("gen_rd", 2'd0, 32'h1);
    rd("mask_rd", 2'd1, 32'hF);
    pulse(4'h4);
    tick();
    rd("t1_pend_e1", 2'd2, 32'h0);
    tick();
    rd("t1_pend_e2", 2'd2, 32'h4);
    chk("t1_req_e2", {31'b0, int_req}, 32'h0);
    tick();
    chk("t1_req_e3", {31'b0, int_req}, 32'h1);
    chk("t1_id", {30'b0, int_id}, 32'h2);
    chk("t1_vec", int_vector, 32'h220);
    rd("t1_status_req", 2'd3, 32'h0000000A);
    ack();
    chk("t1_req_ack", {31'b0, int_req}, 32'h0);
    rd("t1_status_svc", 2'd3, 32'h00000012);
    rd("t1_pend_ack", 2'd2, 32'h0);
    ret();
    chk("t1_insvc_rti", {31'b0, in_service}, 32'h0);
    pulse(4'hA);
    tick();
    tick();
    rd("t2_pend", 2'd2, 32'hA);
    tick();
    chk("t2_req", {31'b0, int_req}, 32'h1);
    chk("t2_id", {30'b0, int_id}, 32'h1);
    chk("t2_vec", int_vector, 32'h210);
    ack();
    rd("t2_pend_ack1", 2'd2, 32'h8);
    tick();
    chk("t2_svc_noreq", {31'b0, int_req}, 32'h0);
    ret();
    chk("t2_idle_noreq", {31'b0, int_req}, 32'h0);
    tick();
    chk("t2_req2", {31'b0, int_req}, 32'h1);
    chk("t2_id2", {30'b0, int_id}, 32'h3);
    chk("t2_vec2", int_vector, 32'h230);
    ack();
    rd("t2_pend_ack2", 2'd2, 32'h0);
    ret();
    wr(2'd1, 32'h0);
    pulse(4'h1);
    tick();
    tick();
    tick();
    chk("t3_masked_req", {31'b0, int_req}, 32'h0);
    rd("t3_masked_pend", 2'd2, 32'h1);
    wr(2'd1, 32'h1);
    chk("t3_unmask_req0", {31'b0, int_req}, 32'h0);
    tick();
    chk("t3_unmask_req", {31'b0, int_req}, 32'h1);
    chk("t3_id", {30'b0, int_id}, 32'h0);
    chk("t3_vec", int_vector, 32'h200);
    ack();
    pulse(4'h1);
    tick();
    tick();
    rd("t5_svc_pend", 2'd2, 32'h1);
    chk("t5_svc_noreq", {31'b0, int_req}, 32'h0);
    chk("t5_svc_insvc", {31'b0, in_service}, 32'h1);
    ret();
    chk("t5_rti_noreq", {31'b0, int_req}, 32'h0);
    tick();
    chk("t5_req", {31'b0, int_req}, 32'h1);
    chk("t5_id", {30'b0, int_id}, 32'h0);
    ack();
    ret();
    pulse(4'h1);
    tick();
    wr(2'd2, 32'h1);
    rd("t5_set_beats_w1c", 2'd2, 32'h1);
    tick();
    chk("t5_req_after", {31'b0, int_req}, 32'h1);
    ret();
    chk("t5_rti_in_req", {31'b0, int_req}, 32'h1);
    chk("t5_rti_in_req_svc", {31'b0, in_service}, 32'h0);
    wr(2'd2, 32'h1);
    rd("t5_w1c", 2'd2, 32'h0);
    wr(2'd1, 32'h0);
    chk("t5_mask_no_retract", {31'b0, int_req}, 32'h1);
    ack();
    chk("t5_ack_svc", {31'b0, in_service}, 32'h1);
    ret();
    wr(2'd1, 32'h1);
    stall = 1'b1;
    pulse(4'h1);
    tick();
    tick();
    tick();
    tick();
    chk("t4_stall_noreq", {31'b0, int_req}, 32'h0);
    rd("t4_stall_pend", 2'd2, 32'h1);
    stall = 1'b0;
    tick();
    chk("t4_unstall_req", {31'b0, int_req}, 32'h1);
    stall = 1'b1;
    tick();
    tick();
    chk("t4_req_held", {31'b0, int_req}, 32'h1);
    ack();
    chk("t4_ack_req", {31'b0, int_req}, 32'h0);
    chk("t4_ack_svc", {31'b0, in_service}, 32'h1);
    stall = 1'b0;
    ret();
    wr(2'd1, 32'hF);
    irq_in = 4'h6;
    tick();
    tick();
    tick();
    tick();
    chk("t6_req", {31'b0, int_req}, 32'h1);
    chk("t6_id", {30'b0, int_id}, 32'h1);
    reset = 1'b1;
    tick();
    chk("t6_rst_req", {31'b0, int_req}, 32'h0);
    chk("t6_rst_vec", int_vector, 32'h200);
    chk("t6_rst_insvc", {31'b0, in_service}, 32'h0);
    rd("t6_rst_pend", 2'd2, 32'h0);
    rd("t6_rst_status", 2'd3, 32'h0);
    rd("t6_rst_gen", 2'd0, 32'h0);
    rd("t6_rst_mask", 2'd1, 32'h0);
    tick();
    reset = 1'b0;
    tick();
    tick();
    rd("t6_pend_e1", 2'd2, 32'h0);
    tick();
    rd("t6_pend_e2", 2'd2, 32'h6);
    chk("t6_gen0_noreq", {31'b0, int_req}, 32'h0);
    wr(2'd2, 32'h6);
    rd("t6_w1c", 2'd2, 32'h0);
    tick();
    tick();
    rd("t6_one_edge", 2'd2, 32'h0);
    irq_in = '0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n, errs);
    $finish;
  end
endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Prioritising, maskable interrupt controller that sits in front of the fetch stage.
- Captures four external interrupt lines as rising edges and holds them as pending bits.
- Offers one request at a time to fetch, with its vector and id, using a req/ack handshake.
- Blocks further requests until the handler returns with rti; software reads and configures it through a small register port.

Parameters:
- VEC_BASE, 32'h00000200, vector of interrupt 0, in PC units (PC increments by 1 per instruction).
- VEC_STRIDE, 32'h00000010, distance between consecutive vectors, in PC units.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- irq_in  input  4  asynchronous interrupt lines; bit 0 has the highest priority.
- stall  input  1  pipeline stall; no new request is issued while it is high.
- int_ack  input  1  from fetch: high in the cycle the PC loads int_vector.
- rti  input  1  return-from-interrupt, single-cycle pulse.
- cfg_we  input  1  register write strobe.
- cfg_addr  input  2  register select.
- cfg_wdata  input  32  write data.
- cfg_rdata  output  32  combinational read data for cfg_addr.
- int_req  output  1  registered interrupt request to fetch.
- int_id  output  2  id of the requested or in-service interrupt.
- int_vector  output  32  VEC_BASE + int_id*VEC_STRIDE, registered together with int_id.
- in_service  output  1  high while in state SERVICE.

Behaviour:
- Reset values: int_req=0, int_id=0, int_vector=VEC_BASE, in_service=0, state IDLE, pending=0, mask=0, gen=0, all sync/edge flops=0.
- A line held high through reset therefore registers as one edge after reset.
- Input path per line: sync1, then sync2, then sync2_d flops. edge = sync2 & ~sync2_d. pending[i] is set on the edge after edge[i] is high.
- Latency: irq_in rises before clock edge E0, giving edge[i] high after E1 and pending set at E2. With gen=1, mask[i]=1 and stall=0, int_req is high after E3.
- Registers:
  - 0: GEN, bit0 = global enable. R/W.
  - 1: MASK[3:0], 1 = enabled. R/W.
  - 2: PENDING[3:0]. Reads current pending; write-1-to-clear.
  - 3: STATUS, read-only: {27'b0, in_service, int_req, 1'b0, int_id}.
  - Unused read bits return 0.
- Pending priority:
  - Set beats write-1-clear in the same cycle.
  - Set beats the ack-clear in the same cycle, so a new edge is never lost.
- FSM:
  - IDLE: if gen & |(pending&mask) & ~stall, go to REQ. int_id and int_vector latch the lowest set index of pending&mask; int_req=1.
  - REQ: int_req held stable. If int_ack, clear pending[int_id], int_req=0, go to SERVICE. Changes to mask or gen do not retract a request that is already issued. stall does not affect REQ.
  - SERVICE: in_service=1; no new request is issued. If rti, go to IDLE. Earliest next int_req is one cycle after the return to IDLE.
- rti is ignored in IDLE and REQ. int_ack is ignored outside REQ.
- Reset mid-operation (any state) returns everything to the reset values on the next edge. Pending is lost.
- A pending bit whose mask is 0 stays pending and is served once it is unmasked.

Test Plan:
- Reset, write GEN=1 and MASK=4'hF, pulse irq_in[2] → PENDING reads 4'h4 at E2; int_req=1 after E3; int_id=2; int_vector=32'h220.
- With gen=1, raise irq_in[3] and irq_in[1] in the same cycle → int_id=1, vector 32'h210. Ack, then rti → next request int_id=3, vector 32'h230. PENDING=0 after the second ack.
- MASK=4'h0, pulse irq_in[0] → no int_req, PENDING=4'h1. Then write MASK=4'h1 → int_req on the following edge, int_id=0, vector 32'h200.
- Hold stall=1 while pending&mask≠0 → int_req stays 0. Drop stall → int_req=1 on the next edge. In REQ, raise stall=1 → int_req stays 1 until ack.
- In SERVICE for id 0, pulse irq_in[0] again → pending[0] is set again with no int_req. After rti, int_req=1 with int_id=0. Also write PENDING=4'h1 in the same cycle a new edge arrives → bit stays set.
- Assert reset while in REQ → int_req=0, PENDING=0, STATUS=0, int_vector=VEC_BASE on the next edge. Lines held high through reset produce exactly one pending set each.
